// File: rtl/memory_pkg.sv
// memory_pkg: shared types, constants and the byte-merge helper used by
// simple_dual_port_memory and its clear sequencer.
package memory_pkg;

    localparam int BYTE_WIDTH    = 8;
    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int MAX_DATAWIDTH = 512;
    localparam int MAX_BYTES     = MAX_DATAWIDTH / BYTE_WIDTH;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } mem_state_e;

    // Replace the bytes of old_word selected by byte_en with those of new_word.
    function automatic logic [MAX_DATAWIDTH-1:0] merge_bytes(
        input logic [MAX_DATAWIDTH-1:0] old_word,
        input logic [MAX_DATAWIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0]     byte_en
    );
        logic [MAX_DATAWIDTH-1:0] merged;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (byte_en[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/memory_clear_sequencer.sv
// memory_clear_sequencer: after reset, walks every address once issuing a
// zero-write, then parks in READY until the next reset.
import memory_pkg::*;

module memory_clear_sequencer #(
    parameter int DATADEPTH    = 1024,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic                    clear_we,
    output logic [ADDRESSWIDTH-1:0] clear_address,
    output logic                    init_busy
);

    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DATADEPTH - 1);

    mem_state_e              state_r;
    mem_state_e              state_next_s;
    logic [ADDRESSWIDTH-1:0] count_r;
    logic [ADDRESSWIDTH-1:0] count_next_s;

    // State and clear-address registers; reset restarts the sweep at address 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= INIT;
            count_r <= {ADDRESSWIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
        end
    end

    // Next state: leave INIT on the edge that clears the last address
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            INIT: begin
                if (count_r == LAST_ADDR) begin
                    state_next_s = READY;
                    count_next_s = count_r;
                end else begin
                    state_next_s = INIT;
                    count_next_s = count_r + ADDRESSWIDTH'(1'b1);
                end
            end
            READY: begin
                state_next_s = READY;
                count_next_s = count_r;
            end
            default: begin
                state_next_s = INIT;
                count_next_s = {ADDRESSWIDTH{1'b0}};
            end
        endcase
    end

    // Outputs decoded straight from the state register
    always_comb begin
        clear_we      = 1'b0;
        init_busy     = 1'b0;
        clear_address = count_r;
        case (state_r)
            INIT: begin
                clear_we  = 1'b1;
                init_busy = 1'b1;
            end
            READY: begin
                clear_we  = 1'b0;
                init_busy = 1'b0;
            end
            default: begin
                clear_we  = 1'b1;
                init_busy = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/simple_dual_port_memory.sv
// simple_dual_port_memory: one write port with byte enables, one registered
// read port with a valid strobe, selectable read-during-write behaviour and
// a post-reset clear sweep.
// Optional macro MEMORY_OUTPUT_REG_EN adds a second register stage on
// read_data/read_valid (read latency 2 instead of 1).
import memory_pkg::*;

module simple_dual_port_memory #(
    parameter int DATAWIDTH    = 32,
    parameter int DATADEPTH    = 1024,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH),
    parameter int WRITE_FIRST  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      write_en,
    input  logic [DATAWIDTH/8-1:0]    write_byte_en,
    input  logic [ADDRESSWIDTH-1:0]   write_address,
    input  logic [DATAWIDTH-1:0]      write_data,
    input  logic                      read_en,
    input  logic [ADDRESSWIDTH-1:0]   read_address,
    output logic [DATAWIDTH-1:0]      read_data,
    output logic                      read_valid,
    output logic                      init_busy
);

    localparam int                    NUM_BYTES   = DATAWIDTH / BYTE_WIDTH;
    // One extra bit so DATADEPTH itself is representable for the range check.
    localparam logic [ADDRESSWIDTH:0] DEPTH_LIMIT = (ADDRESSWIDTH+1)'(DATADEPTH);

    logic [DATAWIDTH-1:0]    mem_r [DATADEPTH];

    logic                    clear_we_s;
    logic [ADDRESSWIDTH-1:0] clear_address_s;
    logic                    init_busy_s;

    logic                    wr_en_s;
    logic [ADDRESSWIDTH-1:0] wr_addr_s;
    logic [DATAWIDTH-1:0]    wr_data_s;
    logic [NUM_BYTES-1:0]    wr_be_s;
    logic                    wr_ok_s;

    logic                    rd_in_range_s;
    logic                    rd_fire_s;
    logic                    collide_s;
    logic [DATAWIDTH-1:0]    old_word_s;
    logic [DATAWIDTH-1:0]    merged_s;
    logic [DATAWIDTH-1:0]    rd_word_s;

    logic [DATAWIDTH-1:0]    read_data_r;
    logic                    read_valid_r;

    memory_clear_sequencer #(
        .DATADEPTH    (DATADEPTH),
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_clear_sequencer (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_we      (clear_we_s),
        .clear_address (clear_address_s),
        .init_busy     (init_busy_s)
    );

    // Write-port mux: the clear sweep owns the port until it finishes
    always_comb begin
        if (init_busy_s) begin
            wr_en_s   = clear_we_s;
            wr_addr_s = clear_address_s;
            wr_data_s = {DATAWIDTH{1'b0}};
            wr_be_s   = {NUM_BYTES{1'b1}};
        end else begin
            wr_en_s   = write_en;
            wr_addr_s = write_address;
            wr_data_s = write_data;
            wr_be_s   = write_byte_en;
        end
        wr_ok_s = wr_en_s & ({1'b0, wr_addr_s} < DEPTH_LIMIT);
    end

    // Byte-lane writes into the array; contents are never reset directly
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be_s[i]) begin
                    mem_r[wr_addr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_s[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word selection: out-of-range reads give zero, collisions may forward
    always_comb begin
        rd_in_range_s = ({1'b0, read_address} < DEPTH_LIMIT);
        rd_fire_s     = read_en & ~init_busy_s;
        collide_s     = write_en & (write_address == read_address);
        if (rd_in_range_s) begin
            old_word_s = mem_r[read_address];
        end else begin
            old_word_s = {DATAWIDTH{1'b0}};
        end
        merged_s = DATAWIDTH'(merge_bytes(MAX_DATAWIDTH'(old_word_s),
                                          MAX_DATAWIDTH'(write_data),
                                          MAX_BYTES'(write_byte_en)));
        if (!rd_in_range_s) begin
            rd_word_s = {DATAWIDTH{1'b0}};
        end else if (collide_s && (WRITE_FIRST != 0)) begin
            rd_word_s = merged_s;
        end else begin
            rd_word_s = old_word_s;
        end
    end

    // First read stage: data holds between reads, valid pulses per read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_r  <= {DATAWIDTH{1'b0}};
            read_valid_r <= 1'b0;
        end else if (rd_fire_s) begin
            read_data_r  <= rd_word_s;
            read_valid_r <= 1'b1;
        end else begin
            read_data_r  <= read_data_r;
            read_valid_r <= 1'b0;
        end
    end

`ifdef MEMORY_OUTPUT_REG_EN
    logic [DATAWIDTH-1:0] read_data_q_r;
    logic                 read_valid_q_r;

    // Extra output stage for timing closure on large arrays
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_q_r  <= {DATAWIDTH{1'b0}};
            read_valid_q_r <= 1'b0;
        end else begin
            read_data_q_r  <= read_data_r;
            read_valid_q_r <= read_valid_r;
        end
    end

    assign read_data  = read_data_q_r;
    assign read_valid = read_valid_q_r;
`else
    assign read_data  = read_data_r;
    assign read_valid = read_valid_r;
`endif

    assign init_busy = init_busy_s;

endmodule

// File: doc/simple_dual_port_memory.md
# simple_dual_port_memory

Parametrised one-write/one-read-port synchronous memory with per-byte write enables, a registered read path with a valid strobe, configurable read-during-write collision behaviour, and a hardware clear sequencer that zeroes the whole array after reset. It serves as the general-purpose buffer RAM for peripherals that fill and drain data concurrently, such as FIFOs, line buffers and DMA staging.

## Interface
Parameters:
- DATAWIDTH, 32, word width in bits; must be a multiple of 8.
- DATADEPTH, 1024, number of words; need not be a power of two.
- ADDRESSWIDTH, $clog2(DATADEPTH), address width.
- WRITE_FIRST, 1, same-address collision: 1 returns the newly written data, 0 returns the old data.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous, active-low reset.
- write_en  input  1  write request.
- write_byte_en  input  DATAWIDTH/8  byte lane enables; bit i covers data bits [8i+7:8i].
- write_address  input  ADDRESSWIDTH  write word address.
- write_data  input  DATAWIDTH  write data.
- read_en  input  1  read request.
- read_address  input  ADDRESSWIDTH  read word address.
- read_data  output  DATAWIDTH  registered read data.
- read_valid  output  1  one-cycle strobe marking fresh read_data.
- init_busy  output  1  high while the clear sequence runs.

## Operation
- FSM states are INIT and READY.
- Reset state is INIT, with the clear counter at 0.
- INIT:
  - Each cycle, write zero to all bytes at address counter.
  - When counter reaches DATADEPTH-1, write that address and then go to READY.
  - init_busy is 1 throughout.
  - write_en and read_en are ignored and dropped, not queued; read_valid stays 0.
- READY:
  - The FSM stays here until reset; init_busy is 0.
  - Write: when write_en=1, update each byte lane whose write_byte_en bit is set. write_byte_en=0 with write_en=1 is a no-op.
  - Read: when read_en=1, sample memory[read_address] into the read pipeline.
- Collision (write_en, read_en and equal addresses in the same cycle):
  - WRITE_FIRST=1: read_data is the merged word. Enabled lanes come from write_data; the others come from the old contents.
  - WRITE_FIRST=0: read_data is the old contents.
- Out-of-range address (address ≥ DATADEPTH): the write is discarded. The read returns 0, and read_valid still pulses.
- read_data holds its last value while no read completes.
- Reset asserted at any time:
  - Outputs go to reset values immediately and the FSM returns to INIT.
  - Array contents are not reset directly; the clear sequence restarts from address 0 after release.
- Reset values: read_data=0, read_valid=0, init_busy=1.

## Timing
- Clear sequence: exactly DATADEPTH cycles from the first clk edge after reset_n deasserts. init_busy falls after the edge that writes address DATADEPTH-1.
- Read latency: read_en sampled at edge N gives read_data and read_valid at edge N+1. With MEMORY_OUTPUT_REG_EN defined, they appear at edge N+2.
- Back-to-back reads are accepted every cycle; throughput is one word per cycle.
- A write at edge N is visible to a non-colliding read sampled at edge N+1 or later.
- No backpressure: read_valid cannot be stalled.

## Configuration
- Macro: MEMORY_OUTPUT_REG_EN.
- Defined: one extra register stage on read_data and read_valid, for timing closure on large arrays. Latency is 2; the collision result is the same as latency 1, only delayed one cycle.
- Undefined: latency 1, no extra stage.
- The reset values of the added stage match the read_data and read_valid reset values.

## Structure
- Package memory_pkg holds:
  - the FSM state enum (INIT, READY);
  - BYTE_WIDTH=8;
  - a function merging a write word into an old word under byte enables, shared with the collision path.
- Sub-module memory_clear_sequencer holds the FSM and address counter. It outputs the clear write enable, the clear address and init_busy.
- The top-level module multiplexes the clear write port against the user write port.

## Test plan
- Clear sequence, DATADEPTH=16: release reset, then:
  - init_busy stays 1 for exactly 16 cycles;
  - afterwards, reads of addresses 0–15 all return 0 with read_valid pulsing each cycle.
- Byte enables, DATAWIDTH=32: write 0xAABBCCDD to address 5 with write_byte_en=1111, then 0x11223344 with write_byte_en=0101. Reading address 5 returns 0xAA22CC44 one cycle later.
- Collision at address 3, old value 0x00000000, write 0xFFFFFFFF with write_byte_en=0011 in the same cycle as the read:
  - WRITE_FIRST=1 returns 0x0000FFFF;
  - WRITE_FIRST=0 returns 0x00000000.
- Requests during INIT: drive write_en and read_en during INIT. read_valid stays 0, and the targeted addresses read 0 after init.
- Mid-init reset, DATADEPTH=16: assert reset_n at clear address 7. Outputs go to reset values asynchronously, and the sequence then completes in a full 16 cycles.
- MEMORY_OUTPUT_REG_EN defined: read_en at edge N gives read_valid at edge N+2. With DATADEPTH=10, a read of address 12 returns 0 and the write to 12 is dropped.
